// File: rtl/lsu_mem_responder_pkg.sv
// rtl/lsu_mem_responder_pkg.sv - shared types and widths for the LSU memory responder
`ifndef LSU_MEM_RESPONDER_VEC
`define LSU_MEM_RESPONDER_VEC
`define Vec(w) logic [(w)-1:0]
`endif

package lsu_mem_responder_pkg;

    localparam int DataWidth = 64;
    localparam int MaskWidth = 8;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_WAIT = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_responder_ram.sv
// rtl/lsu_mem_responder_ram.sv - DEPTH x 64 array with per-byte write enables and registered read
module masked_ram64
    import lsu_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 wen,
    input  logic [IDX_W-1:0]     idx,
    input  logic [MaskWidth-1:0] wmask,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata
);

    `Vec(DataWidth) mem [DEPTH];

    // Byte-masked write or registered read; rdata only changes on an enabled load.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen) begin
                for (int i = 0; i < MaskWidth; i++) begin
                    if (wmask[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// rtl/lsu_mem_responder.sv - latency-programmable load/store responder with valid/ready response
module lsu_mem_responder
    import lsu_mem_responder_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [7:0]  req_wmask,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int          IdxW  = $clog2(DEPTH);
    localparam logic [3:0]  LatM1 = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("lsu_mem_responder: LATENCY must be in 1..15");
    end

    lsu_state_e  state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        err_q;
    logic        load_q;
    logic [63:0] offset;
    logic        addr_err;
    logic        accept;
    logic [63:0] ram_rdata;

    // Range check is done on the full unsigned byte address; low three bits never matter.
    assign offset   = req_addr - BASE_ADDR;
    assign addr_err = (req_addr < BASE_ADDR) || ((offset >> 3) >= 64'(DEPTH));
    assign accept   = (state == LSU_IDLE) && req_valid && !rst;

    // Stores commit and loads are read on the acceptance edge itself.
    masked_ram64 #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .en    (accept && !addr_err),
        .wen   (req_wen),
        .idx   (offset[IdxW+2:3]),
        .wmask (req_wmask),
        .wdata (req_wdata),
        .rdata (ram_rdata)
    );

    // State, latency counter and captured response attributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LSU_IDLE;
            cnt    <= 4'd0;
            err_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (accept) begin
                err_q  <= addr_err;
                load_q <= !req_wen && !addr_err;
            end
        end
    end

    // Next-state: WAIT spends LATENCY-1 cycles so resp_valid lands LATENCY cycles after acceptance.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            LSU_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = LSU_RESP;
                    end else begin
                        state_d = LSU_WAIT;
                        cnt_d   = LatM1;
                    end
                end
            end
            LSU_WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                if (resp_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // Outputs are zero outside RESP so they clear as soon as reset asserts or the handshake completes.
    assign req_ready  = (state == LSU_IDLE) && !rst;
    assign resp_valid = (state == LSU_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && load_q) ? ram_rdata : 64'd0;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// tb/tb_lsu_mem_responder.sv - self-checking bench for lsu_mem_responder
module tb_lsu_mem_responder;

    localparam int          DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv [2];
    logic        rwen [2];
    logic        rr [2];
    logic [63:0] raddr [2];
    logic [63:0] rwd [2];
    logic [7:0]  rmask [2];

    logic        rq1, vld1, err1;
    logic        rq4, vld4, err4;
    logic [63:0] rd1, rd4;

    int checks = 0;
    int failures = 0;

    bit [63:0] mdl [longint];

    lsu_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rq1), .req_addr(raddr[0]),
        .req_wen(rwen[0]), .req_wmask(rmask[0]), .req_wdata(rwd[0]), .resp_valid(vld1),
        .resp_ready(rr[0]), .resp_rdata(rd1), .resp_err(err1)
    );

    lsu_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rq4), .req_addr(raddr[1]),
        .req_wen(rwen[1]), .req_wmask(rmask[1]), .req_wdata(rwd[1]), .resp_valid(vld4),
        .resp_ready(rr[1]), .resp_rdata(rd4), .resp_err(err4)
    );

    function automatic logic rdy(input int d);
        return (d == 1) ? rq4 : rq1;
    endfunction
    function automatic logic vld(input int d);
        return (d == 1) ? vld4 : vld1;
    endfunction
    function automatic logic [63:0] rdat(input int d);
        return (d == 1) ? rd4 : rd1;
    endfunction
    function automatic logic rerr(input int d);
        return (d == 1) ? err4 : err1;
    endfunction
    function automatic int lat_of(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: an address is valid iff it lies in [BASE, BASE + DEPTH*8).
    function automatic bit ref_err(input logic [63:0] a);
        return (a < BASE) || (a >= LIMIT);
    endfunction
    function automatic longint key_of(input int d, input logic [63:0] a);
        return longint'(d) * 100000 + longint'((a - BASE) / 8);
    endfunction

    task automatic model_store(input int d, input logic [63:0] a, input logic [7:0] m, input logic [63:0] wd);
        bit [63:0] w;
        longint k;
        if (ref_err(a)) return;
        k = key_of(d, a);
        w = mdl.exists(k) ? mdl[k] : 64'd0;
        for (int b = 0; b < 8; b++) if (m[b]) w[8*b +: 8] = wd[8*b +: 8];
        mdl[k] = w;
    endtask

    // One full request/response; assumes called #1 after a rising edge.
    task automatic txn(input int d, input logic [63:0] a, input logic w, input logic [7:0] m,
                       input logic [63:0] wd, input int bp,
                       output logic [63:0] rd, output logic er, output int lat);
        int n;
        raddr[d] = a; rwen[d] = w; rmask[d] = m; rwd[d] = wd; rv[d] = 1'b1; rr[d] = 1'b0;
        n = 0;
        while (!rdy(d) && n < 50) begin @(posedge clk); #1; n++; end
        check("req_ready_wait", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        rv[d] = 1'b0;
        lat = 0;
        while (!vld(d) && lat < 50) begin @(posedge clk); #1; lat++; end
        check("resp_valid_wait", 64'(vld(d)), 64'd1);
        rd = rdat(d);
        er = rerr(d);
        for (int i = 0; i < bp; i++) begin
            check("bp_valid", 64'(vld(d)), 64'd1);
            check("bp_rdata_stable", rdat(d), rd);
            check("bp_req_ready", 64'(rdy(d)), 64'd0);
            @(posedge clk); #1;
        end
        check("resp_req_ready_low", 64'(rdy(d)), 64'd0);
        rr[d] = 1'b1;
        @(posedge clk); #1;
        rr[d] = 1'b0;
        check("post_valid", 64'(vld(d)), 64'd0);
        check("post_rdata", rdat(d), 64'd0);
        check("post_err", 64'(rerr(d)), 64'd0);
        check("post_req_ready", 64'(rdy(d)), 64'd1);
    endtask

    // Transaction checked against the reference memory model.
    task automatic op(input int d, input logic [63:0] a, input logic w, input logic [7:0] m,
                      input logic [63:0] wd, input int bp);
        logic [63:0] rd;
        logic er;
        int lat;
        bit e;
        longint k;
        e = ref_err(a);
        k = key_of(d, a);
        txn(d, a, w, m, wd, bp, rd, er, lat);
        check("op_err", 64'(er), 64'(e));
        check("op_latency", 64'(lat), 64'(lat_of(d) - 1));
        if (w || e) check("op_rdata_zero", rd, 64'd0);
        else if (mdl.exists(k)) check("op_load_data", rd, mdl[k]);
        if (w) model_store(d, a, m, wd);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  mask;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [63:0] rd;
        logic er;
        int lat;
        logic [63:0] held;

        vecs[0] = '{64'h8000_0010, 1'b1, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0};
        vecs[1] = '{64'h8000_0010, 1'b0, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0};
        vecs[2] = '{64'h8000_0010, 1'b1, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 64'd0, 1'b0};
        vecs[3] = '{64'h8000_0010, 1'b0, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0};
        vecs[4] = '{64'h7FFF_FFF8, 1'b0, 8'h00, 64'd0, 64'd0, 1'b1};
        vecs[5] = '{LIMIT,         1'b0, 8'h00, 64'd0, 64'd0, 1'b1};
        vecs[6] = '{64'h8000_0010, 1'b0, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0};
        vecs[7] = '{64'h8000_0010, 1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        vecs[8] = '{64'h8000_0017, 1'b0, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0};
        vecs[9] = '{LIMIT - 64'd8, 1'b1, 8'hFF, 64'h0102_0304_0506_0708, 64'd0, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; rwen[d] = 0; rr[d] = 0; raddr[d] = 0; rwd[d] = 0; rmask[d] = 0;
        end

        // Reset state while rst is high
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready_l1", 64'(rq1), 64'd0);
        check("rst_req_ready_l4", 64'(rq4), 64'd0);
        check("rst_valid_l1", 64'(vld1), 64'd0);
        check("rst_rdata_l4", rd4, 64'd0);
        check("rst_err_l4", 64'(err4), 64'd0);
        rst = 0;
        @(posedge clk); #1;
        check("idle_req_ready", 64'(rq1), 64'd1);

        // Directed table on the LATENCY=1 instance
        for (int i = 0; i < 10; i++) begin
            txn(0, vecs[i].addr, vecs[i].wen, vecs[i].mask, vecs[i].wdata, i % 3, rd, er, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd0);
            if (vecs[i].wen) model_store(0, vecs[i].addr, vecs[i].mask, vecs[i].wdata);
        end
        op(0, LIMIT - 64'd8, 1'b0, 8'h00, 64'd0, 0);

        // LATENCY=4 load with six cycles of backpressure
        op(1, 64'h8000_0020, 1'b1, 8'hFF, 64'hCAFE_0000_BEEF_1111, 0);
        txn(1, 64'h8000_0020, 1'b0, 8'h00, 64'd0, 6, rd, er, lat);
        check("l4_latency", 64'(lat), 64'd3);
        check("l4_bp_rdata", rd, 64'hCAFE_0000_BEEF_1111);
        check("l4_bp_err", 64'(er), 64'd0);

        // Reset while a LATENCY=4 store is waiting
        raddr[1] = 64'h8000_0028; rwen[1] = 1; rmask[1] = 8'hFF; rwd[1] = 64'hDEAD_BEEF_CAFE_F00D;
        rv[1] = 1;
        @(posedge clk); #1;
        rv[1] = 0;
        model_store(1, 64'h8000_0028, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
        check("wait_no_valid", 64'(vld4), 64'd0);
        check("wait_req_ready", 64'(rq4), 64'd0);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("async_rst_valid", 64'(vld4), 64'd0);
        check("async_rst_req_ready", 64'(rq4), 64'd0);
        check("async_rst_rdata", rd4, 64'd0);
        check("async_rst_err", 64'(err4), 64'd0);
        @(posedge clk); #1;
        rst = 0;
        held = 0;
        for (int i = 0; i < 6; i++) begin
            held |= 64'(vld4);
            @(posedge clk); #1;
        end
        check("no_stale_valid", held, 64'd0);
        op(1, 64'h8000_0028, 1'b0, 8'h00, 64'd0, 1);

        // Initialise a small working set, then randomized traffic against the model
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                op(d, BASE + 64'(i) * 8, 1'b1, 8'hFF, {$urandom, $urandom}, 0);
        for (int n = 0; n < 200; n++) begin
            int d;
            logic [63:0] a;
            d = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0: a = BASE - 64'($urandom_range(1, 4)) * 8 + 64'($urandom_range(0, 7));
                1: a = LIMIT + 64'($urandom_range(0, 4)) * 8 + 64'($urandom_range(0, 7));
                default: a = BASE + 64'($urandom_range(0, 7)) * 8 + 64'($urandom_range(0, 7));
            endcase
            op(d, a, 1'($urandom), 8'($urandom), {$urandom, $urandom}, $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
